// File: rtl/neuron_b_bwd_pkg.sv
// Shared constants and types for the neuron backward-pass block.
// Holds the Q16.16 word format, the beat index type and the FSM state encoding.
package neuron_b_bwd_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned FRAC  = 16;
   localparam int unsigned N     = 9;
   localparam int unsigned IDX_W = 4;

   typedef logic signed [WIDTH-1:0] word_t;
   typedef logic [IDX_W-1:0]        idx_t;

   localparam word_t ONE      = WIDTH'(1) << FRAC;
   localparam idx_t  LAST_IDX = IDX_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQ     = 2'd1,
      DL     = 2'd2,
      STREAM = 2'd3
   } state_t;

endpackage

// File: rtl/neuron_b_bwd_if.sv
// Handshake bundle between the forward neuron side and the gradient consumer.
// Input side : in_valid/in_ready, y, err, a_flat, w_flat.
// Output side: out_valid/out_ready, out_idx, out_last, grad_w, grad_a, grad_b.
// master = producer/consumer environment, slave = the backward neuron.
import neuron_b_bwd_pkg::*;

interface neuron_b_bwd_if;

   logic                  in_valid;
   logic                  in_ready;
   word_t                 y;
   word_t                 err;
   logic [N*WIDTH-1:0]    a_flat;
   logic [N*WIDTH-1:0]    w_flat;

   logic                  out_valid;
   logic                  out_ready;
   idx_t                  out_idx;
   logic                  out_last;
   word_t                 grad_w;
   word_t                 grad_a;
   word_t                 grad_b;

   modport master (
      output in_valid, y, err, a_flat, w_flat, out_ready,
      input  in_ready, out_valid, out_idx, out_last, grad_w, grad_a, grad_b
   );

   modport slave (
      input  in_valid, y, err, a_flat, w_flat, out_ready,
      output in_ready, out_valid, out_idx, out_last, grad_w, grad_a, grad_b
   );

endinterface

// File: rtl/neuron_b_bwd_fxp_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// low WIDTH bits kept (floor toward -inf, wraps on overflow).
// Ports: a, b operands; p product.
module fxp_mul #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   logic signed [2*WIDTH-1:0] prod;
   logic                      unused_bits;

   assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

   // Taking bits [FRAC +: WIDTH] is the arithmetic shift followed by truncation.
   assign p = prod[FRAC +: WIDTH];

   assign unused_bits = ^{prod[2*WIDTH-1:FRAC+WIDTH], prod[FRAC-1:0]};

endmodule

// File: rtl/neuron_b_bwd.sv
// Backward pass of a 9-input tanh neuron.
// Captures y, err and the a/w pairs, computes delta = err*(1 - y^2) in two
// cycles, then streams N beats of grad_w = delta*a_i, grad_a = delta*w_i,
// grad_b = delta under valid/ready.
// Ports: clk, rst_n (async active-low), bus (slave side of neuron_b_bwd_if).
import neuron_b_bwd_pkg::*;

module neuron_b_bwd (
   input  logic           clk,
   input  logic           rst_n,
   neuron_b_bwd_if.slave  bus
);

   state_t state;
   state_t state_nxt;

   word_t  y_q;
   word_t  err_q;
   word_t  t_q;
   word_t  delta_q;
   word_t  a_q [N];
   word_t  w_q [N];
   idx_t   idx_q;

   logic   load_in;
   logic   load_t;
   logic   load_delta;
   logic   clr_idx;
   logic   step_idx;

   word_t  yy;
   word_t  delta_p;
   word_t  a_sel;
   word_t  w_sel;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, handshake outputs and datapath enables
   always_comb begin
      state_nxt     = state;
      load_in       = 1'b0;
      load_t        = 1'b0;
      load_delta    = 1'b0;
      clr_idx       = 1'b0;
      step_idx      = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               load_in   = 1'b1;
               state_nxt = SQ;
            end
         end
         SQ: begin
            load_t    = 1'b1;
            state_nxt = DL;
         end
         DL: begin
            load_delta = 1'b1;
            clr_idx    = 1'b1;
            state_nxt  = STREAM;
         end
         STREAM: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  clr_idx   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  step_idx  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture registers, derivative pipeline and beat counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         err_q   <= '0;
         t_q     <= '0;
         delta_q <= '0;
         idx_q   <= '0;
         for (int i = 0; i < N; i++) begin
            a_q[i] <= '0;
            w_q[i] <= '0;
         end
      end else begin
         if (load_in) begin
            y_q   <= bus.y;
            err_q <= bus.err;
            for (int i = 0; i < N; i++) begin
               a_q[i] <= $signed(bus.a_flat[i*WIDTH +: WIDTH]);
               w_q[i] <= $signed(bus.w_flat[i*WIDTH +: WIDTH]);
            end
         end
         if (load_t)     t_q     <= ONE - yy;
         if (load_delta) delta_q <= delta_p;
         if (clr_idx)       idx_q <= '0;
         else if (step_idx) idx_q <= idx_q + IDX_W'(1);
      end
   end

   // Select the pair addressed by the current beat
   always_comb begin
      a_sel = '0;
      w_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_sel = a_q[i];
            w_sel = w_q[i];
         end
      end
   end

   fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_sq (.a(y_q),     .b(y_q),  .p(yy));
   fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_dl (.a(err_q),   .b(t_q),  .p(delta_p));
   fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_gw (.a(delta_q), .b(a_sel), .p(bus.grad_w));
   fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ga (.a(delta_q), .b(w_sel), .p(bus.grad_a));

   assign bus.grad_b   = delta_q;
   assign bus.out_idx  = idx_q;
   assign bus.out_last = (state == STREAM) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_neuron_b_bwd.sv
// Self-checking bench for neuron_b_bwd: directed and random bundles from a
// vector table, checked beat by beat against a plain-arithmetic model, plus
// reset, backpressure, input-during-stream and reset-mid-stream sequences.
import neuron_b_bwd_pkg::*;

module tb_neuron_b_bwd;

   typedef word_t vec_t [N];

   typedef struct {
      word_t y;
      word_t err;
      vec_t  a;
      vec_t  w;
      word_t exp_delta;
      word_t exp_gw0;
      word_t exp_ga0;
      int    bp_idx;
      int    bp_len;
      bit    poke;
   } vec_rec_t;

   localparam int NV = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   vec_rec_t tbl [NV];

   neuron_b_bwd_if bus ();

   neuron_b_bwd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Q16.16 multiply: floor of the exact product scaled by 2^-16, wrapped to 32 bits
   function automatic word_t fxmul(input word_t a, input word_t b);
      longint p;
      p = longint'(a) * longint'(b);
      return word_t'(p >>> FRAC);
   endfunction

   function automatic word_t model_delta(input word_t y, input word_t err);
      return fxmul(err, ONE - fxmul(y, y));
   endfunction

   task automatic check(input string name, input int beat,
                        input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s beat %0d: got 0x%0h expected 0x%0h", name, beat, act, exp);
      end
   endtask

   task automatic drive_inputs(input word_t y, input word_t err, input vec_t a, input vec_t w);
      bus.y   = y;
      bus.err = err;
      for (int i = 0; i < N; i++) begin
         bus.a_flat[i*WIDTH +: WIDTH] = a[i];
         bus.w_flat[i*WIDTH +: WIDTH] = w[i];
      end
   endtask

   task automatic check_beat(input vec_rec_t r, input int i);
      check("out_valid", i, bus.out_valid, 1);
      check("out_idx",   i, bus.out_idx, i);
      check("out_last",  i, bus.out_last, (i == int'(N) - 1) ? 1 : 0);
      check("grad_w",    i, bus.grad_w, fxmul(r.exp_delta, r.a[i]));
      check("grad_a",    i, bus.grad_a, fxmul(r.exp_delta, r.w[i]));
      check("grad_b",    i, bus.grad_b, r.exp_delta);
   endtask

   // Called at a falling edge with the block idle; returns at a falling edge, idle again
   task automatic run_bundle(input vec_rec_t r);
      vec_t junk;
      drive_inputs(r.y, r.err, r.a, r.w);
      bus.in_valid = 1'b1;
      check("in_ready_idle", -1, bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("in_ready_sq", -1, bus.in_ready, 0);
      check("valid_sq",    -1, bus.out_valid, 0);
      @(negedge clk);
      check("valid_dl",    -1, bus.out_valid, 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (i == r.bp_idx) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < r.bp_len; k++) begin
               check_beat(r, i);
               @(negedge clk);
            end
            bus.out_ready = 1'b1;
         end
         check_beat(r, i);
         if (i == 0) begin
            check("grad_w_beat0", i, bus.grad_w, r.exp_gw0);
            check("grad_a_beat0", i, bus.grad_a, r.exp_ga0);
         end
         if (r.poke && i == 2) begin
            for (int k = 0; k < N; k++) begin
               junk[k] = word_t'($urandom);
            end
            drive_inputs(word_t'($urandom), word_t'($urandom), junk, junk);
            bus.in_valid = 1'b1;
            check("in_ready_stream", i, bus.in_ready, 0);
            @(negedge clk);
            bus.in_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      check("in_ready_after", -1, bus.in_ready, 1);
      check("valid_after",    -1, bus.out_valid, 0);
   endtask

   task automatic fill_random(inout vec_rec_t r);
      r.y   = word_t'($urandom_range(0, 32'h0002_0000)) - ONE;
      r.err = word_t'($urandom);
      for (int i = 0; i < N; i++) begin
         r.a[i] = word_t'($urandom);
         r.w[i] = word_t'($urandom);
      end
      r.exp_delta = model_delta(r.y, r.err);
      r.exp_gw0   = fxmul(r.exp_delta, r.a[0]);
      r.exp_ga0   = fxmul(r.exp_delta, r.w[0]);
      r.bp_idx    = -1;
      r.bp_len    = 0;
      r.poke      = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.y         = '0;
      bus.err       = '0;
      bus.a_flat    = '0;
      bus.w_flat    = '0;

      for (int v = 0; v < NV; v++) begin
         fill_random(tbl[v]);
      end

      // Basic sweep: y=0 so delta=err=ONE
      tbl[0].y   = '0;
      tbl[0].err = ONE;
      for (int i = 0; i < N; i++) begin
         tbl[0].a[i] = word_t'((i + 1) << FRAC);
         tbl[0].w[i] = -word_t'((i + 1) << FRAC);
      end
      tbl[0].exp_delta = 32'sh0001_0000;
      tbl[0].exp_gw0   = 32'sh0001_0000;
      tbl[0].exp_ga0   = 32'shFFFF_0000;

      // Derivative check at y=0.5
      tbl[1].y         = 32'sh0000_8000;
      tbl[1].err       = 32'sh0001_0000;
      tbl[1].a[0]      = 32'sh0002_0000;
      tbl[1].w[0]      = 32'shFFFF_0000;
      tbl[1].exp_delta = 32'sh0000_C000;
      tbl[1].exp_gw0   = 32'sh0001_8000;
      tbl[1].exp_ga0   = 32'shFFFF_4000;

      // Saturated output: 1 - y^2 = 0
      tbl[2].y         = 32'sh0001_0000;
      tbl[2].exp_delta = '0;
      tbl[2].exp_gw0   = '0;
      tbl[2].exp_ga0   = '0;

      tbl[3].bp_idx = 3;
      tbl[3].bp_len = 5;

      tbl[4].poke = 1'b1;

      for (int v = 5; v < NV; v++) begin
         tbl[v].bp_idx = int'($urandom_range(0, N));
         tbl[v].bp_len = int'($urandom_range(1, 4));
      end

      // Reset values
      #2;
      check("rst_in_ready",  -1, bus.in_ready, 1);
      check("rst_out_valid", -1, bus.out_valid, 0);
      check("rst_out_idx",   -1, bus.out_idx, 0);
      check("rst_out_last",  -1, bus.out_last, 0);
      check("rst_grad_w",    -1, bus.grad_w, 0);
      check("rst_grad_a",    -1, bus.grad_a, 0);
      check("rst_grad_b",    -1, bus.grad_b, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < NV; v++) begin
         run_bundle(tbl[v]);
      end

      // Reset in the middle of a stream
      drive_inputs(tbl[0].y, tbl[0].err, tbl[0].a, tbl[0].w);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      repeat (4) @(negedge clk);
      check("pre_rst_idx",    4, bus.out_idx, 4);
      check("pre_rst_grad_w", 4, bus.grad_w, 32'sh0005_0000);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 4, bus.out_valid, 0);
      check("mid_rst_out_idx",   4, bus.out_idx, 0);
      check("mid_rst_out_last",  4, bus.out_last, 0);
      check("mid_rst_grad_w",    4, bus.grad_w, 0);
      check("mid_rst_grad_a",    4, bus.grad_a, 0);
      check("mid_rst_grad_b",    4, bus.grad_b, 0);
      check("mid_rst_in_ready",  4, bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_bundle(tbl[1]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
